// File: rtl/mem_arb_pkg.sv
// Shared state/owner encodings and default widths for the unified memory-port arbiter.
package mem_arb_pkg;

   localparam int DEF_ADDR_W       = 48;
   localparam int DEF_DATA_W       = 32;
   localparam int DEF_STARVE_LIMIT = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } arb_owner_e;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating counter of cycles the fetch requester has been kept waiting.
// The at_limit flag lets fetch override the fixed load/store priority.
module mem_arb_starve_cnt #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc_i,
   input  logic clr_i,
   output logic at_limit_o
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 2);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Clear wins over increment so a grant always restarts the count
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_limit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (LS), one transaction at a time.
// Define MEM_ARB_TIMEOUT_EN to add a WAIT-state timeout that answers with rdata 0 and resp_err.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
`ifdef MEM_ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT      = 64
`endif
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                ls_req,
   input  logic                ls_we,
   input  logic [ADDR_W-1:0]   ls_addr,
   input  logic [DATA_W-1:0]   ls_wdata,
   input  logic [DATA_W/8-1:0] ls_be,
   output logic                ls_gnt,
   output logic                ls_rvalid,
   output logic [DATA_W-1:0]   ls_rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata
`ifdef MEM_ARB_TIMEOUT_EN
   ,
   output logic                resp_err
`endif
);

   localparam int BE_W = DATA_W / 8;

   arb_state_e        state_q;
   arb_owner_e        owner_q;
   logic              memReq_q;
   logic              memWe_q;
   logic [ADDR_W-1:0] memAddr_q;
   logic [DATA_W-1:0] memWdata_q;
   logic [BE_W-1:0]   memBe_q;
   logic              ifRvalid_q;
   logic              lsRvalid_q;
   logic [DATA_W-1:0] ifRdata_q;
   logic [DATA_W-1:0] lsRdata_q;

   logic              ifGnt;
   logic              lsGnt;
   logic              ifAtLimit;
   logic              rspFire;
   logic [DATA_W-1:0] rspData;

   // LS has priority unless IF has been held off long enough to force its turn
   always_comb begin
      ifGnt = 1'b0;
      lsGnt = 1'b0;
      if (state_q == IDLE) begin
         if (ls_req && (!ifAtLimit || !if_req)) begin
            lsGnt = 1'b1;
         end else if (if_req) begin
            ifGnt = 1'b1;
         end
      end
   end

   mem_arb_starve_cnt #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_starve (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc_i     (if_req && !ifGnt),
      .clr_i     (ifGnt),
      .at_limit_o(ifAtLimit)
   );

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] waitCnt_q;
   logic          rspErr_q;
   logic          timedOut;

   assign timedOut = (state_q == WAIT) && !mem_rvalid && (waitCnt_q == TO_LAST);
   assign rspFire  = ((state_q == WAIT) && mem_rvalid) || timedOut;
   assign rspData  = mem_rvalid ? mem_rdata : '0;
   assign resp_err = rspErr_q;

   // Counts WAIT cycles; the error flag pulses alongside the synthetic response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         waitCnt_q <= '0;
         rspErr_q  <= 1'b0;
      end else begin
         rspErr_q <= timedOut;
         if ((state_q != WAIT) || rspFire) begin
            waitCnt_q <= '0;
         end else begin
            waitCnt_q <= waitCnt_q + TW'(1);
         end
      end
   end
`else
   assign rspFire = (state_q == WAIT) && mem_rvalid;
   assign rspData = mem_rdata;
`endif

   // Transaction sequencer: latch winner, hold request until accepted, route the response to its owner
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         owner_q    <= OWN_IF;
         memReq_q   <= 1'b0;
         memWe_q    <= 1'b0;
         memAddr_q  <= '0;
         memWdata_q <= '0;
         memBe_q    <= '0;
         ifRvalid_q <= 1'b0;
         lsRvalid_q <= 1'b0;
         ifRdata_q  <= '0;
         lsRdata_q  <= '0;
      end else begin
         ifRvalid_q <= 1'b0;
         lsRvalid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (ifGnt || lsGnt) begin
                  owner_q    <= lsGnt ? OWN_LS : OWN_IF;
                  memReq_q   <= 1'b1;
                  memWe_q    <= lsGnt && ls_we;
                  memAddr_q  <= lsGnt ? ls_addr : if_addr;
                  memWdata_q <= lsGnt ? ls_wdata : '0;
                  memBe_q    <= lsGnt ? ls_be : '1;
                  state_q    <= ISSUE;
               end
            end
            ISSUE: begin
               if (mem_gnt) begin
                  memReq_q <= 1'b0;
                  state_q  <= WAIT;
               end
            end
            WAIT: begin
               if (rspFire) begin
                  if (owner_q == OWN_LS) begin
                     lsRvalid_q <= 1'b1;
                     lsRdata_q  <= rspData;
                  end else begin
                     ifRvalid_q <= 1'b1;
                     ifRdata_q  <= rspData;
                  end
                  state_q <= IDLE;
               end
            end
            default: begin
               memReq_q <= 1'b0;
               state_q  <= IDLE;
            end
         endcase
      end
   end

   assign if_gnt    = ifGnt;
   assign ls_gnt    = lsGnt;
   assign if_rvalid = ifRvalid_q;
   assign ls_rvalid = lsRvalid_q;
   assign if_rdata  = ifRdata_q;
   assign ls_rdata  = lsRdata_q;
   assign mem_req   = memReq_q;
   assign mem_we    = memWe_q;
   assign mem_addr  = memAddr_q;
   assign mem_wdata = memWdata_q;
   assign mem_be    = memBe_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, hand-written corner sequences and a response scoreboard.
// Define MEM_ARB_TIMEOUT_EN to also exercise the WAIT timeout.
module tb_mem_port_arbiter;

   localparam int ADDR_W = 48;
   localparam int DATA_W = 32;
   localparam int BE_W   = DATA_W / 8;
`ifdef MEM_ARB_TIMEOUT_EN
   localparam int TB_TIMEOUT = 8;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              if_req = 1'b0;
   logic [ADDR_W-1:0] if_addr = '0;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic              ls_req = 1'b0;
   logic              ls_we = 1'b0;
   logic [ADDR_W-1:0] ls_addr = '0;
   logic [DATA_W-1:0] ls_wdata = '0;
   logic [BE_W-1:0]   ls_be = '0;
   logic              ls_gnt;
   logic              ls_rvalid;
   logic [DATA_W-1:0] ls_rdata;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [BE_W-1:0]   mem_be;
   logic              mem_gnt = 1'b0;
   logic              mem_rvalid = 1'b0;
   logic [DATA_W-1:0] mem_rdata = '0;
`ifdef MEM_ARB_TIMEOUT_EN
   logic              resp_err;
`endif

   typedef struct {
      logic              isLs;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [BE_W-1:0]   be;
      logic [DATA_W-1:0] rdVal;
      int                gntDelay;
      int                rspDelay;
      logic              expWe;
      logic [BE_W-1:0]   expBe;
   } vec_t;

   typedef struct {
      logic              isLs;
      logic [DATA_W-1:0] data;
      logic              err;
      int                expCyc;
   } sb_t;

   vec_t vecs[4];
   sb_t  sbQ[$];

   int nCmp = 0;
   int nFail = 0;
   int cycNo = 0;

   int                gntDelay = 0;
   int                rspDelay = 0;
   int                gntCnt = 0;
   int                rspCnt = 0;
   bit                rspArmed = 1'b0;
   bit                forceRsp = 1'b0;
   logic [DATA_W-1:0] memRdVal = '0;
   logic [DATA_W-1:0] rspData = '0;
   logic [DATA_W-1:0] expIfRd = '0;
   logic [DATA_W-1:0] expLsRd = '0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .STARVE_LIMIT(4)
`ifdef MEM_ARB_TIMEOUT_EN
      ,
      .TIMEOUT     (TB_TIMEOUT)
`endif
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .ls_req    (ls_req),
      .ls_we     (ls_we),
      .ls_addr   (ls_addr),
      .ls_wdata  (ls_wdata),
      .ls_be     (ls_be),
      .ls_gnt    (ls_gnt),
      .ls_rvalid (ls_rvalid),
      .ls_rdata  (ls_rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_gnt   (mem_gnt),
      .mem_rvalid(mem_rvalid),
      .mem_rdata (mem_rdata)
`ifdef MEM_ARB_TIMEOUT_EN
      ,
      .resp_err  (resp_err)
`endif
   );

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nCmp++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic checkResetZero(input string tag);
      checkOutput({tag, " mem_req"}, mem_req, 0);
      checkOutput({tag, " mem_we"}, mem_we, 0);
      checkOutput({tag, " mem_addr"}, mem_addr, 0);
      checkOutput({tag, " mem_wdata"}, mem_wdata, 0);
      checkOutput({tag, " mem_be"}, mem_be, 0);
      checkOutput({tag, " if_gnt"}, if_gnt, 0);
      checkOutput({tag, " ls_gnt"}, ls_gnt, 0);
      checkOutput({tag, " if_rvalid"}, if_rvalid, 0);
      checkOutput({tag, " ls_rvalid"}, ls_rvalid, 0);
      checkOutput({tag, " if_rdata"}, if_rdata, 0);
      checkOutput({tag, " ls_rdata"}, ls_rdata, 0);
`ifdef MEM_ARB_TIMEOUT_EN
      checkOutput({tag, " resp_err"}, resp_err, 0);
`endif
   endtask

   // One clock step: memory model drives its inputs, then responses are scored against the queue
   task automatic tick();
      sb_t e;
      @(negedge clk);
      cycNo++;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (forceRsp) begin
         mem_rvalid = 1'b1;
      end else if (rspArmed) begin
         if (rspCnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rspData;
            rspArmed   = 1'b0;
         end else begin
            rspCnt--;
         end
      end else if (mem_req) begin
         if (gntCnt == 0) begin
            mem_gnt  = 1'b1;
            gntCnt   = gntDelay;
            rspArmed = (rspDelay >= 0);
            rspCnt   = rspDelay;
            rspData  = memRdVal;
         end else begin
            gntCnt--;
         end
      end

      if (if_rvalid && ls_rvalid) begin
         nCmp++;
         nFail++;
         $display("[TB] FAIL dual rvalid: actual both set required one at cycle %0d", cycNo);
      end
      if (if_rvalid || ls_rvalid) begin
         if (sbQ.size() == 0) begin
            nCmp++;
            nFail++;
            $display("[TB] FAIL unexpected rvalid: actual pulse required none at cycle %0d", cycNo);
         end else begin
            e = sbQ.pop_front();
            checkOutput("rvalid owner is LS", ls_rvalid, e.isLs);
            checkOutput("rvalid cycle", cycNo, e.expCyc);
`ifdef MEM_ARB_TIMEOUT_EN
            checkOutput("resp_err on response", resp_err, e.err);
`endif
            if (e.isLs) expLsRd = e.data;
            else expIfRd = e.data;
         end
      end
`ifdef MEM_ARB_TIMEOUT_EN
      else begin
         checkOutput("resp_err idle", resp_err, 0);
      end
`endif
      checkOutput("if_rdata", if_rdata, expIfRd);
      checkOutput("ls_rdata", ls_rdata, expLsRd);
   endtask

   task automatic drain(input string tag);
      for (int n = 0; n < 200 && sbQ.size() != 0; n++) tick();
      checkOutput({tag, " responses outstanding"}, sbQ.size(), 0);
   endtask

   // One complete transaction from a table record; called at a negedge with the arbiter idle
   task automatic applyStimulus(input int idx, input vec_t v);
      bit gotGnt;
      gntDelay = v.gntDelay;
      rspDelay = v.rspDelay;
      gntCnt   = v.gntDelay;
      memRdVal = v.rdVal;
      if (v.isLs) begin
         if_req   = 1'b0;
         ls_req   = 1'b1;
         ls_we    = v.we;
         ls_addr  = v.addr;
         ls_wdata = v.wdata;
         ls_be    = v.be;
      end else begin
         ls_req   = 1'b0;
         ls_we    = 1'b1;
         ls_be    = '0;
         ls_wdata = $urandom;
         if_req   = 1'b1;
         if_addr  = v.addr;
      end
      #1;
      checkOutput($sformatf("v%0d if_gnt", idx), if_gnt, !v.isLs);
      checkOutput($sformatf("v%0d ls_gnt", idx), ls_gnt, v.isLs);
      sbQ.push_back('{isLs: v.isLs, data: v.rdVal, err: 1'b0,
                      expCyc: cycNo + 3 + v.gntDelay + v.rspDelay});
      tick();
      if_req = 1'b0;
      ls_req = 1'b0;
      gotGnt = 1'b0;
      for (int n = 0; n < 20 && !gotGnt; n++) begin
         checkOutput($sformatf("v%0d mem_req", idx), mem_req, 1);
         checkOutput($sformatf("v%0d mem_we", idx), mem_we, v.expWe);
         checkOutput($sformatf("v%0d mem_addr", idx), mem_addr, v.addr);
         checkOutput($sformatf("v%0d mem_be", idx), mem_be, v.expBe);
         if (v.expWe) checkOutput($sformatf("v%0d mem_wdata", idx), mem_wdata, v.wdata);
         gotGnt = mem_gnt;
         tick();
      end
      checkOutput($sformatf("v%0d mem accepted", idx), gotGnt, 1);
      drain($sformatf("v%0d", idx));
      checkOutput($sformatf("v%0d mem_req released", idx), mem_req, 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual still running required finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int               k;
      int               startCyc;
      logic [3:0]       contOrder;
      logic [ADDR_W-1:0] lastAddr;

      vecs[0] = '{isLs: 1'b0, we: 1'b0, addr: 48'h100, wdata: 32'h0, be: 4'h0,
                  rdVal: 32'hDEADBEEF, gntDelay: 0, rspDelay: 0, expWe: 1'b0, expBe: 4'hF};
      vecs[1] = '{isLs: 1'b1, we: 1'b1, addr: 48'h200, wdata: 32'h12345678, be: 4'b0011,
                  rdVal: 32'hA5A5A5A5, gntDelay: 3, rspDelay: 0, expWe: 1'b1, expBe: 4'b0011};
      vecs[2] = '{isLs: 1'b1, we: 1'b0, addr: 48'hFFFF_FFFF_FFFC, wdata: 32'h0, be: 4'hF,
                  rdVal: 32'h0BADF00D, gntDelay: 1, rspDelay: 2, expWe: 1'b0, expBe: 4'hF};
      vecs[3] = '{isLs: 1'b0, we: 1'b0, addr: 48'h4, wdata: 32'h0, be: 4'h0,
                  rdVal: 32'h00000001, gntDelay: 0, rspDelay: 4, expWe: 1'b0, expBe: 4'hF};

      $display("[TB] reset");
      tick();
      tick();
      checkResetZero("reset");
      rst_n = 1'b1;
      tick();

      $display("[TB] vector table");
      for (int i = 0; i < 4; i++) applyStimulus(i, vecs[i]);

      // Reset lands while the fetch sits in WAIT; the late memory response must be dropped
      $display("[TB] reset mid-WAIT");
      gntDelay = 0;
      gntCnt   = 0;
      rspDelay = 100;
      memRdVal = 32'hCAFEF00D;
      if_addr  = 48'h300;
      if_req   = 1'b1;
      #1;
      checkOutput("midrst if_gnt", if_gnt, 1);
      tick();
      if_req = 1'b0;
      tick();
      checkOutput("midrst in WAIT mem_req", mem_req, 0);
      rst_n = 1'b0;
      #1;
      checkResetZero("midrst");
      rspArmed = 1'b0;
      expIfRd  = '0;
      expLsRd  = '0;
      tick();
      rst_n = 1'b1;
      tick();
      forceRsp = 1'b1;
      tick();
      forceRsp = 1'b0;
      repeat (3) tick();
      checkResetZero("postrst");
      applyStimulus(4, vecs[0]);

      // Both requesters held: LS, LS, then IF forced in by starvation, then LS again
      $display("[TB] contention");
      contOrder = 4'b1011;
      gntDelay  = 0;
      gntCnt    = 0;
      rspDelay  = 0;
      if_addr   = 48'h400;
      ls_we     = 1'b0;
      ls_addr   = 48'h500;
      ls_be     = 4'hF;
      if_req    = 1'b1;
      ls_req    = 1'b1;
      k         = 0;
      startCyc  = cycNo;
      for (int n = 0; n < 40 && k < 4; n++) begin
         #1;
         if (if_gnt || ls_gnt) begin
            checkOutput($sformatf("cont%0d ls_gnt", k), ls_gnt, contOrder[k]);
            checkOutput($sformatf("cont%0d if_gnt", k), if_gnt, !contOrder[k]);
            checkOutput($sformatf("cont%0d grant cycle", k), cycNo - startCyc, 3 * k);
            memRdVal = $urandom;
            sbQ.push_back('{isLs: contOrder[k], data: memRdVal, err: 1'b0, expCyc: cycNo + 3});
            k++;
         end
         tick();
      end
      if_req = 1'b0;
      ls_req = 1'b0;
      checkOutput("cont grant count", k, 4);
      drain("cont");

      // Three back-to-back fetches with zero-wait memory
      $display("[TB] back-to-back fetch");
      k        = 0;
      startCyc = cycNo;
      if_req   = 1'b1;
      for (int n = 0; n < 30 && k < 3; n++) begin
         if_addr = 48'h1000 + 48'(4 * k);
         #1;
         if (mem_req) checkOutput("b2b mem_addr", mem_addr, lastAddr);
         if (if_gnt) begin
            checkOutput($sformatf("b2b%0d grant cycle", k), cycNo - startCyc, 3 * k);
            memRdVal = $urandom;
            sbQ.push_back('{isLs: 1'b0, data: memRdVal, err: 1'b0, expCyc: cycNo + 3});
            lastAddr = if_addr;
            k++;
         end
         tick();
      end
      if_req = 1'b0;
      checkOutput("b2b grant count", k, 3);
      drain("b2b");

`ifdef MEM_ARB_TIMEOUT_EN
      // Memory accepts but never answers; a late response afterwards must be ignored
      $display("[TB] timeout");
      gntDelay = 0;
      gntCnt   = 0;
      rspDelay = -1;
      ls_we    = 1'b0;
      ls_addr  = 48'h600;
      ls_be    = 4'hF;
      ls_req   = 1'b1;
      #1;
      checkOutput("to ls_gnt", ls_gnt, 1);
      sbQ.push_back('{isLs: 1'b1, data: '0, err: 1'b1, expCyc: cycNo + 2 + TB_TIMEOUT});
      tick();
      ls_req = 1'b0;
      drain("to");
      forceRsp = 1'b1;
      tick();
      forceRsp = 1'b0;
      repeat (3) tick();
      checkOutput("to late ls_rdata", ls_rdata, 0);
`endif

      checkOutput("scoreboard empty", sbQ.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule
